keypad_encoder: RTL and testbench
=================================

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 Parameter SCAN_CYCLES, default 4: clocks each column is driven; legal range is 2 to 255.
REQ-002 Parameter DEBOUNCE_SCANS, default 3: consecutive identical full-scan results needed to accept a press or a release; legal range is 1 to 15.
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 row  input  4  keypad row sense, asynchronous pad inputs; high means a key in the driven column is closed.
REQ-006 col  output  4  one-hot active-high column drive.
REQ-007 digit  output  4  value 0-9 of the accepted digit key; holds its value between events.
REQ-008 store_digit  output  1  single-cycle strobe marking a digit key accepted.
REQ-009 func  output  3  code 0-5 of the accepted function key; holds its value between events.
REQ-010 func_strobe  output  1  single-cycle strobe marking a function key accepted.

Function
REQ-011 row shall pass through a 2-flop synchronizer before any use.
REQ-012 col shall rotate 0001 -> 0010 -> 0100 -> 1000 -> 0001, advancing every SCAN_CYCLES clocks; one full scan takes 4*SCAN_CYCLES clocks.
REQ-013 Synchronized row shall be sampled in the last clock of each column window; key index = row*4 + column.
REQ-014 At end of each scan, the result shall be classified as NONE (no closures), SINGLE(k) (exactly one closure) or MULTI (two or more closures).
REQ-015 Key map, rows 0-3 left to right: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
REQ-016 Function codes: A=0, B=1, C=2, D=3, *=4, #=5.
REQ-017 FSM states: IDLE, DEBOUNCE, HELD, RELEASE; evaluated only at end of scan.
REQ-018 IDLE: SINGLE(k) -> DEBOUNCE, candidate=k, count=1; NONE or MULTI -> stay in IDLE.
REQ-019 DEBOUNCE: SINGLE(same k) -> count+1; when count reaches DEBOUNCE_SCANS, emit the event and go to HELD. Any other result -> IDLE, no event.
REQ-020 HELD: NONE -> RELEASE, count=1; otherwise stay in HELD, with no auto-repeat.
REQ-021 RELEASE: NONE -> count+1; when count reaches DEBOUNCE_SCANS -> IDLE. SINGLE or MULTI -> HELD.
REQ-022 With DEBOUNCE_SCANS=1, the transitions IDLE -> DEBOUNCE and HELD -> RELEASE shall complete immediately: the event is emitted, or IDLE is reached, on that same evaluation.
REQ-023 Event emission: in the clock after the end-of-scan evaluation, digit/store_digit or func/func_strobe shall update; store_digit and func_strobe shall never be high together.
REQ-024 Strobes shall be high for exactly one clock per accepted press.
REQ-025 A candidate change during DEBOUNCE shall restart from IDLE; it shall not transfer directly to the new key.

Reset
REQ-026 Reset values: col=0001, digit=0, func=0, store_digit=0, func_strobe=0, state=IDLE, count=0, scan counters=0, synchronizer flops=0.
REQ-027 Reset asserted mid-debounce or mid-hold shall discard the candidate; after release, scanning shall restart at column 0 with no pending event.

Structure
REQ-028 Package keypad_pkg shall hold the state enum, the 16-entry key map (is_digit flag plus 4-bit value), and the function-code constants.
REQ-029 Sub-module row_sync (4-bit 2-flop synchronizer, clk/rst) shall be instantiated once; all other logic stays in keypad_encoder.

Verification (SCAN_CYCLES=4, DEBOUNCE_SCANS=3, scan = 16 clocks)
REQ-030 Hold '5' (row1, col1) for 10 scans -> exactly one store_digit with digit=5, one clock after the 3rd end-of-scan showing it; func_strobe stays 0.
REQ-031 '7' for 2 scans, open 1 scan, '7' for 3 scans -> exactly one store_digit with digit=7, after the final 3-scan run.
REQ-032 '1' and '2' held together for 8 scans -> no strobes; col keeps rotating.
REQ-033 Press '#' for 4 scans -> one func_strobe with func=5; store_digit stays 0.
REQ-034 Hold '0', release 1 scan, re-press -> no second event; then release 3 scans, re-press 3 scans -> second store_digit with digit=0.
REQ-035 Assert rst mid-DEBOUNCE -> all outputs at reset values immediately; after release, col=0001 and no strobe until a fresh 3-scan press.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, key map and scan classification for the 4x4 keypad encoder.
package keypad_pkg;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;

    // Debounce/hold tracking states; advanced only at end of a full scan.
    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    // Outcome of one complete scan of all 16 keys.
    typedef enum logic [1:0] {
        SCAN_NONE,
        SCAN_SINGLE,
        SCAN_MULTI
    } scan_kind_t;

    typedef struct packed {
        scan_kind_t kind;
        logic [3:0] key;
    } scan_result_t;

    // One key-map entry: digit keys carry 0-9, function keys a 3-bit code.
    typedef struct packed {
        logic       is_digit;
        logic [3:0] value;
    } key_entry_t;

    localparam logic [2:0] FUNC_A    = 3'd0;
    localparam logic [2:0] FUNC_B    = 3'd1;
    localparam logic [2:0] FUNC_C    = 3'd2;
    localparam logic [2:0] FUNC_D    = 3'd3;
    localparam logic [2:0] FUNC_STAR = 3'd4;
    localparam logic [2:0] FUNC_HASH = 3'd5;

    // Indexed by row*4 + column. Layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
    localparam key_entry_t KEY_MAP [16] = '{
        '{1'b1, 4'd1}, '{1'b1, 4'd2}, '{1'b1, 4'd3}, '{1'b0, {1'b0, FUNC_A}},
        '{1'b1, 4'd4}, '{1'b1, 4'd5}, '{1'b1, 4'd6}, '{1'b0, {1'b0, FUNC_B}},
        '{1'b1, 4'd7}, '{1'b1, 4'd8}, '{1'b1, 4'd9}, '{1'b0, {1'b0, FUNC_C}},
        '{1'b0, {1'b0, FUNC_STAR}}, '{1'b1, 4'd0},
        '{1'b0, {1'b0, FUNC_HASH}}, '{1'b0, {1'b0, FUNC_D}}
    };

    // Reduce a 16-bit closure vector to NONE, SINGLE(key) or MULTI.
    function automatic scan_result_t classify_scan(input logic [15:0] closed);
        scan_result_t res;
        int           ones;
        logic [3:0]   key;
        ones = 0;
        key  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (closed[i]) begin
                ones = ones + 1;
                key  = 4'(i);
            end
        end
        res.key = key;
        if (ones == 0) begin
            res.kind = SCAN_NONE;
        end else if (ones == 1) begin
            res.kind = SCAN_SINGLE;
        end else begin
            res.kind = SCAN_MULTI;
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_encoder_row_sync.sv
// Two-flop synchronizer bringing the asynchronous row pads into the clk domain.
module row_sync
    import keypad_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_ROWS-1:0] d,
    output logic [KEY_ROWS-1:0] q
);

    logic [KEY_ROWS-1:0] meta;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            // NOTE: non-blocking so q takes the old meta, forming a true two-stage chain.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 keypad scanner with per-scan debounce, emitting one strobe per accepted press.
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES    = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] digit,
    output logic       store_digit,
    output logic [2:0] func,
    output logic       func_strobe
);

    localparam logic [7:0] CYC_LAST = 8'(SCAN_CYCLES - 1);
    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_SCANS);

    logic [3:0]   row_s;
    logic [7:0]   cyc_cnt;
    logic [1:0]   col_idx;
    logic [15:0]  scan_acc;
    logic [15:0]  col_bits;
    logic [15:0]  scan_full;
    logic         window_end;
    logic         scan_end;
    scan_result_t res;
    key_entry_t   emit_entry;

    state_t       state;
    state_t       state_nxt;
    logic [3:0]   count;
    logic [3:0]   count_nxt;
    logic [3:0]   cand;
    logic [3:0]   cand_nxt;
    logic         emit;

    row_sync u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row),
        .q   (row_s)
    );

    assign col        = 4'b0001 << col_idx;
    assign window_end = (cyc_cnt == CYC_LAST);
    assign scan_end   = window_end && (col_idx == 2'd3);
    assign scan_full  = scan_acc | col_bits;
    assign res        = classify_scan(scan_full);
    assign emit_entry = KEY_MAP[res.key];

    // Place the synchronized rows of the current column at their key indices.
    always_comb begin
        // NOTE: default every comb output before the loop so no path leaves it unassigned (no latch).
        col_bits = '0;
        for (int r = 0; r < KEY_ROWS; r++) begin
            col_bits[{2'(r), col_idx}] = row_s[r];
        end
    end

    // Column window timing and accumulation of closures over one full scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt  <= '0;
            col_idx  <= '0;
            scan_acc <= '0;
        end else if (window_end) begin
            cyc_cnt  <= '0;
            col_idx  <= col_idx + 2'd1;
            scan_acc <= scan_end ? '0 : scan_full;
        end else begin
            cyc_cnt  <= cyc_cnt + 8'd1;
        end
    end

    // Debounce state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            cand  <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            cand  <= cand_nxt;
        end
    end

    // Next-state logic; a candidate change always falls back to IDLE first.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        cand_nxt  = cand;
        emit      = 1'b0;
        if (scan_end) begin
            case (state)
                IDLE: begin
                    if (res.kind == SCAN_SINGLE) begin
                        cand_nxt = res.key;
                        if (DEB_LAST == 4'd1) begin
                            emit      = 1'b1;
                            state_nxt = HELD;
                            count_nxt = '0;
                        end else begin
                            state_nxt = DEBOUNCE;
                            count_nxt = 4'd1;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (res.kind == SCAN_SINGLE && res.key == cand) begin
                        if (count + 4'd1 == DEB_LAST) begin
                            emit      = 1'b1;
                            state_nxt = HELD;
                            count_nxt = '0;
                        end else begin
                            count_nxt = count + 4'd1;
                        end
                    end else begin
                        state_nxt = IDLE;
                        count_nxt = '0;
                    end
                end
                HELD: begin
                    if (res.kind == SCAN_NONE) begin
                        if (DEB_LAST == 4'd1) begin
                            state_nxt = IDLE;
                            count_nxt = '0;
                        end else begin
                            state_nxt = RELEASE;
                            count_nxt = 4'd1;
                        end
                    end
                end
                RELEASE: begin
                    if (res.kind == SCAN_NONE) begin
                        if (count + 4'd1 == DEB_LAST) begin
                            state_nxt = IDLE;
                            count_nxt = '0;
                        end else begin
                            count_nxt = count + 4'd1;
                        end
                    end else begin
                        state_nxt = HELD;
                        count_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

    // Registered event outputs: values hold, strobes pulse for one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit       <= '0;
            func        <= '0;
            store_digit <= 1'b0;
            func_strobe <= 1'b0;
        end else begin
            store_digit <= 1'b0;
            func_strobe <= 1'b0;
            if (emit) begin
                if (emit_entry.is_digit) begin
                    digit       <= emit_entry.value;
                    store_digit <= 1'b1;
                end else begin
                    func        <= emit_entry.value[2:0];
                    func_strobe <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// Scan-level stimulus for keypad_encoder with an event scoreboard.
module tb_keypad_encoder;

    localparam int SCAN = 16;

    localparam logic [15:0] K_1    = 16'h0001;
    localparam logic [15:0] K_2    = 16'h0002;
    localparam logic [15:0] K_A    = 16'h0008;
    localparam logic [15:0] K_5    = 16'h0020;
    localparam logic [15:0] K_7    = 16'h0100;
    localparam logic [15:0] K_8    = 16'h0200;
    localparam logic [15:0] K_9    = 16'h0400;
    localparam logic [15:0] K_0    = 16'h2000;
    localparam logic [15:0] K_HASH = 16'h4000;
    localparam logic [15:0] K_D    = 16'h8000;

    typedef struct {
        logic       is_digit;
        logic [3:0] value;
        int         cycle;
    } exp_t;

    typedef struct {
        logic [15:0] keys;
        int          scans;
        int          ev_scan;
        logic        is_digit;
        logic [3:0]  value;
    } step_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  digit;
    logic        store_digit;
    logic [2:0]  func;
    logic        func_strobe;
    logic [15:0] pressed = '0;

    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   tb_cycle = 0;
    int   scan_no  = 0;
    exp_t sb[$];
    step_t steps[$];

    keypad_encoder #(
        .SCAN_CYCLES    (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row         (row),
        .col         (col),
        .digit       (digit),
        .store_digit (store_digit),
        .func        (func),
        .func_strobe (func_strobe)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) tb_cycle <= 0;
        else     tb_cycle <= tb_cycle + 1;
    end

    function automatic logic [3:0] row_from(input logic [15:0] p, input logic [3:0] c);
        logic [3:0] r;
        r = '0;
        for (int ri = 0; ri < 4; ri++) begin
            for (int ci = 0; ci < 4; ci++) begin
                if (c[ci] && p[ri*4 + ci]) r[ri] = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb row = row_from(pressed, col);

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, actual, expected, tb_cycle);
        end
    endtask

    // Scoreboard: each strobe pops one expected event and checks kind, value and timing.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && (store_digit || func_strobe)) begin
            check("strobe_exclusive", 32'(store_digit & func_strobe), 32'd0);
            if (sb.size() == 0) begin
                check("spurious_strobe", 32'({store_digit, func_strobe}), 32'd0);
            end else begin
                e = sb.pop_front();
                check("strobe_kind", 32'(store_digit), 32'(e.is_digit));
                if (e.is_digit) check("digit_value", 32'(digit), 32'(e.value));
                else            check("func_value", 32'(func), 32'(e.value));
                check("strobe_cycle", 32'(tb_cycle), 32'(e.cycle));
            end
        end
    end

    task automatic run_scan(input logic [15:0] keys, input bit ev, input logic is_d, input logic [3:0] val);
        exp_t       e;
        logic [3:0] want_col;
        pressed = keys;
        scan_no++;
        if (ev) begin
            e.is_digit = is_d;
            e.value    = val;
            e.cycle    = SCAN * scan_no;
            sb.push_back(e);
        end
        for (int i = 0; i < SCAN; i++) begin
            @(negedge clk);
            want_col = 4'(1 << ((tb_cycle / 4) % 4));
            check("col_rotation", 32'(col), 32'(want_col));
        end
    endtask

    initial begin
        steps.push_back('{K_5,        10, 3, 1'b1, 4'd5});
        steps.push_back('{16'h0,       3, 0, 1'b0, 4'd0});
        steps.push_back('{K_7,         2, 0, 1'b0, 4'd0});
        steps.push_back('{16'h0,       1, 0, 1'b0, 4'd0});
        steps.push_back('{K_7,         3, 3, 1'b1, 4'd7});
        steps.push_back('{16'h0,       3, 0, 1'b0, 4'd0});
        steps.push_back('{K_1 | K_2,   8, 0, 1'b0, 4'd0});
        steps.push_back('{16'h0,       1, 0, 1'b0, 4'd0});
        steps.push_back('{K_HASH,      4, 3, 1'b0, 4'd5});
        steps.push_back('{16'h0,       3, 0, 1'b0, 4'd0});
        steps.push_back('{K_A,         3, 3, 1'b0, 4'd0});
        steps.push_back('{16'h0,       3, 0, 1'b0, 4'd0});
        steps.push_back('{K_5,         2, 0, 1'b0, 4'd0});
        steps.push_back('{K_8,         4, 4, 1'b1, 4'd8});
        steps.push_back('{16'h0,       3, 0, 1'b0, 4'd0});
        steps.push_back('{K_0,         3, 3, 1'b1, 4'd0});
        steps.push_back('{16'h0,       1, 0, 1'b0, 4'd0});
        steps.push_back('{K_0,         3, 0, 1'b0, 4'd0});
        steps.push_back('{16'h0,       3, 0, 1'b0, 4'd0});
        steps.push_back('{K_0,         3, 3, 1'b1, 4'd0});
        steps.push_back('{16'h0,       3, 0, 1'b0, 4'd0});
        steps.push_back('{K_D,         3, 3, 1'b0, 4'd3});
        steps.push_back('{16'h0,       3, 0, 1'b0, 4'd0});

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_col",         32'(col),         32'd1);
        check("rst_digit",       32'(digit),       32'd0);
        check("rst_func",        32'(func),        32'd0);
        check("rst_store_digit", 32'(store_digit), 32'd0);
        check("rst_func_strobe", 32'(func_strobe), 32'd0);
        rst     = 1'b0;
        scan_no = 0;

        // Table of scan-level key patterns with hand-derived event timing.
        foreach (steps[s]) begin
            for (int i = 1; i <= steps[s].scans; i++) begin
                run_scan(steps[s].keys, (i == steps[s].ev_scan), steps[s].is_digit, steps[s].value);
            end
            if (steps[s].keys == 16'h0) check("pending_events", 32'(sb.size()), 32'd0);
        end

        // Digit holds between events.
        for (int i = 1; i <= 3; i++) run_scan(K_9, (i == 3), 1'b1, 4'd9);
        for (int i = 1; i <= 3; i++) run_scan(16'h0, 1'b0, 1'b0, 4'd0);
        check("digit_hold", 32'(digit), 32'd9);
        check("func_hold",  32'(func),  32'd3);

        // Reset in the middle of a debounce discards the candidate.
        run_scan(K_8, 1'b0, 1'b0, 4'd0);
        run_scan(K_8, 1'b0, 1'b0, 4'd0);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_col",         32'(col),         32'd1);
        check("midrst_digit",       32'(digit),       32'd0);
        check("midrst_func",        32'(func),        32'd0);
        check("midrst_store_digit", 32'(store_digit), 32'd0);
        check("midrst_func_strobe", 32'(func_strobe), 32'd0);
        check("midrst_pending",     32'(sb.size()),   32'd0);
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        scan_no = 0;
        check("post_rst_col", 32'(col), 32'd1);
        for (int i = 1; i <= 3; i++) run_scan(K_8, (i == 3), 1'b1, 4'd8);
        for (int i = 1; i <= 3; i++) run_scan(16'h0, 1'b0, 1'b0, 4'd0);
        check("pending_final", 32'(sb.size()), 32'd0);
        check("final_digit",   32'(digit),     32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
